// File: rtl/washing_machine_timer.sv
// Phase duration timer for the washing-machine controller: a free-running prescaler
// produces ticks, and a per-phase tick count ends in a single-cycle TIMER_DONE pulse.
module washing_machine_timer #(
    parameter int TICK_DIV = 1000,
    parameter int CNT_W    = 12,
    parameter int DUR_SEL0 = 30,
    parameter int DUR_SEL1 = 600,
    parameter int DUR_SEL2 = 900,
    parameter int DUR_SEL3 = 300
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             TIMER_EN,
    input  logic [1:0]       TIMER_SEL,
    output logic             TIMER_DONE,
    output logic             TIMER_BUSY,
    output logic [CNT_W-1:0] TIME_LEFT
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        EXPIRE = 2'b10,
        HOLD   = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [1:0]       sel_q, sel_d;
    logic             load;

    function automatic logic [CNT_W-1:0] dur(input logic [1:0] s);
        case (s)
            2'b00:   dur = CNT_W'(DUR_SEL0);
            2'b01:   dur = CNT_W'(DUR_SEL1);
            2'b10:   dur = CNT_W'(DUR_SEL2);
            default: dur = CNT_W'(DUR_SEL3);
        endcase
    endfunction

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            presc_q <= '0;
            sel_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        presc_d = presc_q;
        sel_d   = sel_q;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (TIMER_EN) load = 1'b1;
            end
            RUN: begin
                if (!TIMER_EN) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    presc_d = '0;
                end else if (TIMER_SEL != sel_q) begin
                    load = 1'b1;
                end else if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    // Reaching the last tick always expires; the counter never wraps.
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = EXPIRE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            EXPIRE: begin
                if (!TIMER_EN) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    presc_d = '0;
                end else if (TIMER_SEL != sel_q) begin
                    // A zero-length phase right after expiry would pulse DONE twice in a row,
                    // so it is absorbed into HOLD instead.
                    if (dur(TIMER_SEL) == '0) begin
                        sel_d   = TIMER_SEL;
                        state_d = HOLD;
                    end else begin
                        load = 1'b1;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!TIMER_EN) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    presc_d = '0;
                end else if (TIMER_SEL != sel_q) begin
                    load = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                presc_d = '0;
            end
        endcase

        if (load) begin
            sel_d   = TIMER_SEL;
            presc_d = '0;
            cnt_d   = dur(TIMER_SEL);
            state_d = (dur(TIMER_SEL) == '0) ? EXPIRE : RUN;
        end
    end

    assign TIMER_DONE = (state_q == EXPIRE);
    assign TIMER_BUSY = (state_q == RUN);
    assign TIME_LEFT  = (state_q == RUN) ? cnt_q : '0;

endmodule

// File: tb/tb_washing_machine_timer.sv
// Self-checking bench for washing_machine_timer: vector table, directed corner cases,
// and random enable/select traffic against a cycle-countdown reference model.
module tb_washing_machine_timer;

    localparam int TD = 4;
    localparam int DURS [4] = '{0, 3, 5, 2};
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_WAIT = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       en  = 1'b0;
    logic [1:0] sel = 2'b00;
    logic       done, busy;
    logic [3:0] left;

    int checks = 0;
    int failures = 0;

    // Model: phase mode, selected phase, and clock cycles remaining until expiry.
    int m_mode = M_IDLE;
    int m_cur  = 0;
    int m_rem  = 0;
    logic prev_done = 1'b0;

    typedef struct {
        bit         en;
        logic [1:0] sel;
        bit         done;
        bit         busy;
        int         left;
    } vec_t;
    vec_t tbl[$];

    washing_machine_timer #(
        .TICK_DIV(4), .CNT_W(4),
        .DUR_SEL0(0), .DUR_SEL1(3), .DUR_SEL2(5), .DUR_SEL3(2)
    ) dut (
        .CLK(CLK), .RST(RST), .TIMER_EN(en), .TIMER_SEL(sel),
        .TIMER_DONE(done), .TIMER_BUSY(busy), .TIME_LEFT(left)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_start(input int s);
        m_cur  = s;
        m_rem  = DURS[s] * TD;
        m_mode = (m_rem == 0) ? M_DONE : M_RUN;
    endtask

    task automatic m_step(input bit e, input int s);
        case (m_mode)
            M_IDLE: if (e) m_start(s);
            M_RUN: begin
                if (!e) m_mode = M_IDLE;
                else if (s != m_cur) m_start(s);
                else begin
                    m_rem--;
                    if (m_rem == 0) m_mode = M_DONE;
                end
            end
            M_DONE: begin
                if (!e) m_mode = M_IDLE;
                else if (s != m_cur) begin
                    if (DURS[s] == 0) begin
                        m_cur  = s;
                        m_mode = M_WAIT;
                    end else m_start(s);
                end else m_mode = M_WAIT;
            end
            default: begin
                if (!e) m_mode = M_IDLE;
                else if (s != m_cur) m_start(s);
            end
        endcase
    endtask

    task automatic m_reset();
        m_mode = M_IDLE;
        m_cur  = 0;
        m_rem  = 0;
        prev_done = 1'b0;
    endtask

    task automatic cyc(input bit e, input logic [1:0] s);
        int exp_left;
        en  = e;
        sel = s;
        @(posedge CLK);
        m_step(e, int'(s));
        #1;
        exp_left = (m_mode == M_RUN) ? (m_rem + TD - 1) / TD : 0;
        chk("model_done", 32'(done), 32'(m_mode == M_DONE));
        chk("model_busy", 32'(busy), 32'(m_mode == M_RUN));
        chk("model_left", 32'(left), 32'(exp_left));
        chk("no_double_done", 32'(prev_done & done), 32'd0);
        prev_done = done;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         en_r;
        logic [1:0] sel_r;

        for (int j = 0; j < 12; j++) tbl.push_back('{1'b1, 2'b01, 1'b0, 1'b1, 3 - j / 4});
        tbl.push_back('{1'b1, 2'b01, 1'b1, 1'b0, 0});
        tbl.push_back('{1'b1, 2'b01, 1'b0, 1'b0, 0});
        tbl.push_back('{1'b1, 2'b01, 1'b0, 1'b0, 0});
        tbl.push_back('{1'b1, 2'b11, 1'b0, 1'b1, 2});
        for (int j = 1; j < 8; j++) tbl.push_back('{1'b1, 2'b11, 1'b0, 1'b1, 2 - j / 4});
        tbl.push_back('{1'b1, 2'b11, 1'b1, 1'b0, 0});
        tbl.push_back('{1'b1, 2'b11, 1'b0, 1'b0, 0});
        tbl.push_back('{0, 2'b11, 1'b0, 1'b0, 0});

        #2;
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_left", 32'(left), 32'd0);
        #10 RST = 1'b1;

        // Medium wash, expiry, HOLD, then wash-to-spin reload.
        for (int i = 0; i < tbl.size(); i++) begin
            en  = tbl[i].en;
            sel = tbl[i].sel;
            @(posedge CLK);
            m_step(tbl[i].en, int'(tbl[i].sel));
            #1;
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].done));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("vec%0d_left", i), 32'(left), 32'(tbl[i].left));
            prev_done = done;
        end

        // Asynchronous reset in the middle of a run.
        for (int i = 0; i < 5; i++) cyc(1'b1, 2'b01);
        chk("prerst_left", 32'(left), 32'd2);
        #2 RST = 1'b0;
        #1;
        chk("asyncrst_done", 32'(done), 32'd0);
        chk("asyncrst_busy", 32'(busy), 32'd0);
        chk("asyncrst_left", 32'(left), 32'd0);
        m_reset();
        #2 RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 2'b01);
            chk("postrst_busy", 32'(busy), 32'd0);
        end

        // Abort after 9 cycles, then a full 20-cycle count.
        for (int i = 0; i < 9; i++) cyc(1'b1, 2'b10);
        cyc(1'b0, 2'b10);
        chk("abort_left", 32'(left), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        cyc(1'b0, 2'b10);
        cyc(1'b1, 2'b10);
        chk("rerun_left", 32'(left), 32'd5);
        for (int i = 1; i < 20; i++) begin
            cyc(1'b1, 2'b10);
            chk("rerun_early_done", 32'(done), 32'd0);
        end
        cyc(1'b1, 2'b10);
        chk("rerun_done20", 32'(done), 32'd1);
        cyc(1'b0, 2'b10);

        // Zero-length phase: DONE in the sampling cycle only, never busy.
        cyc(1'b1, 2'b00);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 2'b00);
            chk("zero_after_done", 32'(done), 32'd0);
            chk("zero_after_busy", 32'(busy), 32'd0);
        end
        cyc(1'b0, 2'b00);

        // Enable drops on the final-tick edge: abort wins.
        for (int i = 0; i < 12; i++) cyc(1'b1, 2'b01);
        cyc(1'b0, 2'b01);
        chk("race_abort_done", 32'(done), 32'd0);
        chk("race_abort_busy", 32'(busy), 32'd0);
        chk("race_abort_left", 32'(left), 32'd0);
        cyc(1'b0, 2'b01);
        chk("race_abort_done2", 32'(done), 32'd0);

        // Select changes on the final-tick edge: restart wins.
        for (int i = 0; i < 12; i++) cyc(1'b1, 2'b01);
        cyc(1'b1, 2'b11);
        chk("race_sel_done", 32'(done), 32'd0);
        chk("race_sel_busy", 32'(busy), 32'd1);
        chk("race_sel_left", 32'(left), 32'd2);
        cyc(1'b0, 2'b11);

        // Random enable/select traffic against the model.
        en_r  = 1'b0;
        sel_r = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            if (en_r) begin
                if ($urandom_range(0, 99) < 3) en_r = 1'b0;
            end else begin
                if ($urandom_range(0, 99) < 20) en_r = 1'b1;
            end
            if ($urandom_range(0, 99) < 5) sel_r = 2'($urandom_range(0, 3));
            cyc(en_r, sel_r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/washing_machine_timer.md
# washing_machine_timer

Duration timer serving the washing-machine controller FSM. Accepts the controller's TIMER_EN/TIMER_SEL request and returns a one-cycle TIMER_DONE pulse after the selected phase duration has elapsed. A free-running prescaler derives a phase tick from CLK. The block sits beside the controller and is the only source of TIMER_DONE.

## Interface
- TICK_DIV, 1000: CLK cycles per tick, >= 1; prescaler width is $clog2(TICK_DIV), minimum 1.
- CNT_W, 12: width of tick counter and TIME_LEFT.
- DUR_SEL0, 30: ticks for TIMER_SEL = 00 (pre-rinse).
- DUR_SEL1, 600: ticks for 01 (medium-water wash).
- DUR_SEL2, 900: ticks for 10 (high-water wash).
- DUR_SEL3, 300: ticks for 11 (spin).
- CLK  input  1  system clock, all state on rising edge.
- RST  input  1  asynchronous, active-low reset.
- TIMER_EN  input  1  controller requests timing; level, high for the whole phase.
- TIMER_SEL  input  2  phase/duration select, sampled every cycle.
- TIMER_DONE  output  1  registered; high exactly one cycle on expiry.
- TIMER_BUSY  output  1  registered; high while counting (state RUN).
- TIME_LEFT  output  CNT_W  remaining ticks; 0 outside RUN.

## Operation
- States: IDLE, RUN, EXPIRE, HOLD. Registers: state, cnt, presc, sel_q.
- DUR(s) = DUR_SELs truncated to CNT_W bits.
- IDLE: TIMER_EN=1 -> sel_q<=TIMER_SEL, cnt<=DUR(TIMER_SEL), presc<=0, go RUN; if DUR(TIMER_SEL)=0, go EXPIRE directly, cnt<=0.
- RUN, priority order:
  - TIMER_EN=0 -> IDLE, cnt<=0, presc<=0 (abort, no pause/resume).
  - TIMER_SEL != sel_q -> restart: reload cnt with the new duration, presc<=0, sel_q<=TIMER_SEL; stay RUN (EXPIRE if new DUR=0).
  - else presc==TICK_DIV-1 (tick): presc<=0; cnt==1 -> cnt<=0, go EXPIRE; otherwise cnt<=cnt-1.
  - else presc<=presc+1.
- EXPIRE (TIMER_DONE=1, one cycle only): TIMER_EN=0 -> IDLE; TIMER_SEL != sel_q -> reload and RUN; else HOLD.
- HOLD: TIMER_DONE=0; waits so a still-asserted TIMER_EN cannot retrigger. TIMER_EN=0 -> IDLE; TIMER_SEL != sel_q with TIMER_EN=1 -> reload and RUN.
- Outputs are Moore:
  - TIMER_DONE = (state==EXPIRE).
  - TIMER_BUSY = (state==RUN).
  - TIME_LEFT = cnt in RUN, else 0.
- Counter never wraps. cnt is only decremented from values >= 2; reaching 1 on a tick always expires.

## Timing
- Reset (RST=0, asynchronous, any state including mid-RUN): state=IDLE, cnt=0, presc=0, sel_q=00. TIMER_DONE=0, TIMER_BUSY=0, TIME_LEFT=0.
- Release of RST is synchronous in effect: first transition at the first rising edge with RST=1.
- Latency: TIMER_EN sampled high at edge k with duration D>0 -> TIMER_DONE high from edge k+D*TICK_DIV to edge k+D*TICK_DIV+1.
- D=0 -> TIMER_DONE high from edge k to edge k+1.
- TICK_DIV=1: a tick occurs every cycle in RUN.
- Restart on select change takes effect at the sampling edge; full new duration measured from that edge, same formula.
- TIMER_EN falling on the same edge as the final tick: abort wins, no TIMER_DONE.
- Select change on the final-tick edge: restart wins, no TIMER_DONE.
- TIMER_DONE is never asserted in two consecutive cycles.

## Test plan
Overrides: TICK_DIV=4, DUR_SEL0=0, DUR_SEL1=3, DUR_SEL2=5, DUR_SEL3=2, CNT_W=4.
- Reset: RST=0 mid-RUN with TIME_LEFT=2 -> all outputs 0 immediately, without waiting for an edge. After release, TIMER_EN=0 -> stays IDLE.
- Medium wash: TIMER_EN=1, SEL=01 at edge k -> TIMER_BUSY=1, TIME_LEFT 3,2,1 stepping every 4 cycles. TIMER_DONE=1 only in cycle k+12. HOLD thereafter with TIMER_DONE=0 while EN stays high.
- Wash-to-spin: after expiry in HOLD, SEL 01->11 with EN=1 -> RUN reloads TIME_LEFT=2. TIMER_DONE 8 cycles after the change edge.
- Abort: SEL=10, drop TIMER_EN after 9 cycles -> IDLE, TIME_LEFT=0, no TIMER_DONE. Re-enable -> full 20-cycle count again.
- Zero duration: TIMER_EN=1, SEL=00 at edge k -> TIMER_DONE high for cycle k only, TIMER_BUSY never 1.
- Race: drop TIMER_EN on the final-tick edge of SEL=01 -> no TIMER_DONE, state IDLE.
